// File: rtl/key_history_pkg.sv
// Shared types and defaults for the keypad digit history.
// The operation decode lives here so every user sees the same priority order.
package key_history_pkg;

    localparam int DEFAULT_DEPTH = 2;
    localparam int DEFAULT_KEY_W = 16;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_CLEAR
    } hist_op_t;

    // clear > replace > push > pop > hold
    function automatic hist_op_t decode_op(
        input logic clear,
        input logic accept,
        input logic backspace
    );
        hist_op_t op;
        op = OP_HOLD;
        if (clear) begin
            op = OP_CLEAR;
        end else if (accept && backspace) begin
            op = OP_REPLACE;
        end else if (accept) begin
            op = OP_PUSH;
        end else if (backspace) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/key_history_rise_detect.sv
// Single-cycle pulse on a 0->1 transition of a level input.
// The delayed copy clears on reset, so an input already high after release counts as an edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/key_history.sv
// Shift-register history of entered keypad digits, newest at index 0.
// Supports push, backspace (pop), replace-newest and clear, with change/drop pulses.
module key_history
    import key_history_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int KEY_W     = DEFAULT_KEY_W,
    parameter int EDGE_MODE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_key,
    input  logic [KEY_W-1:0]             key_value,
    input  logic                         backspace,
    input  logic                         clear,
    output logic [DEPTH*KEY_W-1:0]       digits,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         updated,
    output logic                         dropped
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic             accept;
    hist_op_t         op;
    logic [KEY_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic             updated_r;
    logic             dropped_r;
    logic             is_empty;
    logic             is_full;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            rise_detect u_rise (
                .clk   (clk),
                .reset (reset),
                .in    (new_key),
                .pulse (accept)
            );
        end else begin : g_level
            assign accept = new_key;
        end
    endgenerate

    always_comb begin
        op = decode_op(clear, accept, backspace);
    end

    assign is_empty = (count_r == '0);
    assign is_full  = (count_r == DEPTH_C);

    // Slots at or above count are kept at zero by every operation, so the
    // flattened view can expose the array directly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count_r   <= '0;
            updated_r <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            updated_r <= 1'b0;
            dropped_r <= 1'b0;
            case (op)
                OP_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                    count_r   <= '0;
                    updated_r <= 1'b1;
                end
                OP_REPLACE: begin
                    mem[0] <= key_value;
                    if (is_empty) begin
                        count_r <= ONE_C;
                    end
                    updated_r <= 1'b1;
                end
                OP_PUSH: begin
                    mem[0] <= key_value;
                    for (int i = 1; i < DEPTH; i++) begin
                        mem[i] <= mem[i-1];
                    end
                    if (is_full) begin
                        dropped_r <= 1'b1;
                    end else begin
                        count_r <= count_r + ONE_C;
                    end
                    updated_r <= 1'b1;
                end
                OP_POP: begin
                    if (!is_empty) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            mem[i] <= mem[i+1];
                        end
                        mem[DEPTH-1] <= '0;
                        count_r      <= count_r - ONE_C;
                        updated_r    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign digits[KEY_W*gi +: KEY_W] = mem[gi];
        end
    endgenerate

    assign count   = count_r;
    assign full    = is_full;
    assign updated = updated_r;
    assign dropped = dropped_r;

endmodule

// File: tb/tb_key_history.sv
// Bench for key_history: edge-mode and level-mode instances share stimulus and
// are compared every cycle against a queue-based model of the digit history.
module tb_key_history;

    localparam int DEPTH = 4;
    localparam int KEY_W = 16;

    logic        clk;
    logic        reset;
    logic        new_key;
    logic [15:0] key_value;
    logic        backspace;
    logic        clear;

    logic [63:0] digits_e1, digits_e0;
    logic [2:0]  count_e1, count_e0;
    logic        full_e1, full_e0;
    logic        updated_e1, updated_e0;
    logic        dropped_e1, dropped_e0;

    key_history #(.DEPTH(DEPTH), .KEY_W(KEY_W), .EDGE_MODE(1)) dut_e1 (
        .clk       (clk),
        .reset     (reset),
        .new_key   (new_key),
        .key_value (key_value),
        .backspace (backspace),
        .clear     (clear),
        .digits    (digits_e1),
        .count     (count_e1),
        .full      (full_e1),
        .updated   (updated_e1),
        .dropped   (dropped_e1)
    );

    key_history #(.DEPTH(DEPTH), .KEY_W(KEY_W), .EDGE_MODE(0)) dut_e0 (
        .clk       (clk),
        .reset     (reset),
        .new_key   (new_key),
        .key_value (key_value),
        .backspace (backspace),
        .clear     (clear),
        .digits    (digits_e0),
        .count     (count_e0),
        .full      (full_e0),
        .updated   (updated_e0),
        .dropped   (dropped_e0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queue of key values, newest at the front.
    int m1[$];
    int m0[$];
    bit u1, d1, u0, d0;
    bit prev_nk;

    int n_upd1 = 0;
    int n_drop1 = 0;
    int n_drop0 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] flat(input int q[$]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < q.size()) r[16*i +: 16] = q[i][15:0];
        end
        return r;
    endfunction

    function automatic void model_step(input int qi[$], input bit acc, input bit bs,
                                       input bit clr, input int kv,
                                       output int qo[$], output bit upd, output bit drp);
        qo  = qi;
        upd = 1'b0;
        drp = 1'b0;
        if (clr) begin
            qo.delete();
            upd = 1'b1;
        end else if (acc && bs) begin
            if (qo.size() == 0) qo.push_back(kv);
            else qo[0] = kv;
            upd = 1'b1;
        end else if (acc) begin
            qo.push_front(kv);
            if (qo.size() > DEPTH) begin
                void'(qo.pop_back());
                drp = 1'b1;
            end
            upd = 1'b1;
        end else if (bs && qo.size() > 0) begin
            void'(qo.pop_front());
            upd = 1'b1;
        end
    endfunction

    task automatic compare_all();
        check("e1_digits",  digits_e1,  flat(m1));
        check("e1_count",   count_e1,   m1.size());
        check("e1_full",    full_e1,    m1.size() == DEPTH);
        check("e1_updated", updated_e1, u1);
        check("e1_dropped", dropped_e1, d1);
        check("e0_digits",  digits_e0,  flat(m0));
        check("e0_count",   count_e0,   m0.size());
        check("e0_full",    full_e0,    m0.size() == DEPTH);
        check("e0_updated", updated_e0, u0);
        check("e0_dropped", dropped_e0, d0);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic nk, input logic [15:0] kv, input logic bs,
                       input logic clr, input logic rst);
        new_key   = nk;
        key_value = kv;
        backspace = bs;
        clear     = clr;
        reset     = rst;
        if (!rst) begin
            m1.delete();
            m0.delete();
            u1 = 0; d1 = 0; u0 = 0; d0 = 0;
            prev_nk = 1'b0;
        end else begin
            model_step(m1, nk && !prev_nk, bs, clr, int'(kv), m1, u1, d1);
            model_step(m0, nk, bs, clr, int'(kv), m0, u0, d0);
            prev_nk = nk;
        end
        @(posedge clk);
        #1;
        compare_all();
        if (updated_e1) n_upd1++;
        if (dropped_e1) n_drop1++;
        if (dropped_e0) n_drop0++;
    endtask

    task automatic push(input logic [15:0] kv);
        cyc(1'b1, kv, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    int base;

    initial begin
        new_key = 0; key_value = 0; backspace = 0; clear = 0; reset = 0;

        // Reset state, with other inputs active to show reset wins.
        cyc(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("rst_count", count_e1, 0);
        check("rst_digits", digits_e1, 64'h0);

        // Three pushes.
        base = n_upd1;
        push(16'h0001); push(16'h0002); push(16'h0003);
        check("push3_digits", digits_e1, 64'h0000_0001_0002_0003);
        check("push3_count", count_e1, 3);
        check("push3_full", full_e1, 0);
        check("push3_updates", n_upd1 - base, 3);

        // Backspace, then three more; the last one finds it empty.
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        check("pop_digits", digits_e1, 64'h0000_0000_0001_0002);
        check("pop_count", count_e1, 2);
        base = n_upd1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        check("pop_empty_count", count_e1, 0);
        check("pop_empty_updates", n_upd1 - base, 2);

        // Five pushes into depth four.
        base = n_drop1;
        for (int k = 1; k <= 5; k++) push(16'(k));
        check("over_digits", digits_e1, 64'h0002_0003_0004_0005);
        check("over_count", count_e1, 4);
        check("over_full", full_e1, 1);
        check("over_drops", n_drop1 - base, 1);

        // Replace from count 2 and from empty.
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        push(16'h0001); push(16'h0002);
        cyc(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b1);
        check("repl_digits", digits_e1, 64'h0000_0000_0001_00AA);
        check("repl_count", count_e1, 2);
        idle();
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b1);
        check("repl0_digits", digits_e1, 64'h0000_0000_0000_00AA);
        check("repl0_count", count_e1, 1);
        idle();

        // new_key held high for ten cycles right after reset release.
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        base = n_drop0;
        for (int k = 1; k <= 10; k++) cyc(1'b1, 16'(k), 1'b0, 1'b0, 1'b1);
        idle();
        check("hold_e1_count", count_e1, 1);
        check("hold_e1_digits", digits_e1, 64'h0000_0000_0000_0001);
        check("hold_e0_count", count_e0, 4);
        check("hold_e0_digits", digits_e0, 64'h0007_0008_0009_000A);
        check("hold_e0_drops", n_drop0 - base, 6);

        // Clear beats a simultaneous replace request.
        push(16'h0003); push(16'h0004);
        cyc(1'b1, 16'h0055, 1'b1, 1'b1, 1'b1);
        check("clr_digits", digits_e1, 64'h0);
        check("clr_count", count_e1, 0);
        check("clr_updated", updated_e1, 1);
        idle();

        // Reset in the middle of a push stream.
        push(16'h0007);
        cyc(1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
        check("midrst_digits", digits_e1, 64'h0);
        check("midrst_count", count_e1, 0);
        check("midrst_full", full_e0, 0);
        check("midrst_updated", updated_e1, 0);
        check("midrst_dropped", dropped_e0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            cyc(1'($urandom_range(0, 1)),
                16'($urandom()),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 99) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
